// File: rtl/mp_add_seq_pkg.sv
// Shared types for the multi-precision add/sub controller.
// Holds the FSM state encoding and the adder slice width.
package mp_add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_seq_rca.sv
// 8-bit ripple-carry adder slice.
// Ports: a, b operand bytes; ci carry-in; s sum byte; co carry-out.
module mp_add_seq_rca
  import mp_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic [BYTE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) |
               (c[i] & (a[i] ^ b[i]));
    end
    co = c[BYTE_W];
  end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/sub, one byte slice per cycle, LSB first.
// Ports: clk, rst (sync, high); in_valid/in_ready with a, b, cin, sub;
// out_valid/out_ready with sum, cout (1 = no borrow on sub), ovf.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int IDX_W =
    (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NBYTES - 1);
  localparam int MSB = BYTE_W - 1;

  state_t state;
  state_t state_n;

  logic [NBYTES-1:0][BYTE_W-1:0] a_reg;
  logic [NBYTES-1:0][BYTE_W-1:0] b_reg;
  logic [NBYTES-1:0][BYTE_W-1:0] sum_reg;

  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             cout_reg;
  logic             ovf_reg;

  logic [BYTE_W-1:0] add_s;
  logic              add_co;
  logic              accept;
  logic              last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == LAST);

  mp_add_seq_rca u_rca (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = BUSY;
      end
      BUSY: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Subtract is folded in at accept time:
  // B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
    end else if (state == BUSY) begin
      sum_reg[idx] <= add_s;
      carry        <= add_co;
      idx          <= idx + IDX_W'(1);
      if (last) begin
        cout_reg <= add_co;
        ovf_reg  <=
          (a_reg[NBYTES-1][MSB] ==
           b_reg[NBYTES-1][MSB]) &&
          (add_s[MSB] != a_reg[NBYTES-1][MSB]);
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (NBYTES=4 and NBYTES=1).
// Directed scenarios plus random ops against an arithmetic model.
module tb_mp_add_seq;

  logic clk;
  logic rst;

  logic        in_valid, in_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic        cout, ovf;

  logic       in_valid1, in_ready1;
  logic [7:0] a1, b1, sum1;
  logic       cin1, sub1;
  logic       out_valid1, out_ready1;
  logic       cout1, ovf1;

  int checks = 0;
  int errors = 0;

  mp_add_seq #(.NBYTES(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  mp_add_seq #(.NBYTES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .sub       (sub1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .ovf       (ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: unsigned result for sum/cout,
  // true signed range test for ovf.
  function automatic void ref_model(
    input  int          w,
    input  logic [31:0] xa,
    input  logic [31:0] xb,
    input  logic        xc,
    input  logic        xs,
    output logic [31:0] rs,
    output logic        rc,
    output logic        ro
  );
    longint full, half, ua, ub, sa, sb, r, sr;
    full = 64'sd1 << w;
    half = full / 2;
    ua = longint'(xa) & (full - 1);
    ub = longint'(xb) & (full - 1);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (xs) begin
      r  = ua - ub;
      rc = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(xc);
      rc = (r >= full);
      sr = sa + sb + longint'(xc);
    end
    rs = 32'(r & (full - 1));
    ro = (sr < -half) || (sr >= half);
  endfunction

  task automatic run_op4(
    input  logic [31:0] xa,
    input  logic [31:0] xb,
    input  logic        xc,
    input  logic        xs,
    input  int          stall,
    output logic [31:0] rs,
    output logic        rc,
    output logic        ro,
    output int          lat,
    output logic        stable
  );
    int   n;
    logic acc;
    a = xa; b = xb; cin = xc; sub = xs;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!acc) lat = -1;
    rs = sum; rc = cout; ro = ovf;
    stable = out_valid;
    repeat (stall) begin
      tick();
      if (!out_valid || in_ready ||
          sum !== rs || cout !== rc ||
          ovf !== ro)
        stable = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    if (out_valid || !in_ready) stable = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic run_op1(
    input  logic [7:0] xa,
    input  logic [7:0] xb,
    input  logic       xc,
    input  logic       xs,
    input  int         stall,
    output logic [7:0] rs,
    output logic       rc,
    output logic       ro,
    output int         lat,
    output logic       stable
  );
    int   n;
    logic acc;
    a1 = xa; b1 = xb; cin1 = xc; sub1 = xs;
    in_valid1 = 1'b1;
    out_ready1 = 1'b0;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = in_ready1;
      tick();
      n++;
    end
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 40) begin
      tick();
      lat++;
    end
    if (!acc) lat = -1;
    rs = sum1; rc = cout1; ro = ovf1;
    stable = out_valid1;
    repeat (stall) begin
      tick();
      if (!out_valid1 || in_ready1 ||
          sum1 !== rs || cout1 !== rc ||
          ovf1 !== ro)
        stable = 1'b0;
    end
    out_ready1 = 1'b1;
    tick();
    if (out_valid1 || !in_ready1) stable = 1'b0;
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset4: rdy=%b vld=%b sum=%h c=%b o=%b, want 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    checks++;
    if ({in_ready1, out_valid1, sum1, cout1, ovf1}
        !== {1'b1, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset1: rdy=%b vld=%b sum=%h c=%b o=%b, want 1 0 0 0 0",
               in_ready1, out_valid1, sum1, cout1, ovf1);
    end
  endtask

  task automatic check_dir(
    input string       name,
    input logic [31:0] xa,
    input logic [31:0] xb,
    input logic        xc,
    input logic        xs,
    input logic [31:0] es,
    input logic        ec,
    input logic        eo
  );
    logic [31:0] rs;
    logic        rc, ro, st;
    int          lat;
    run_op4(xa, xb, xc, xs, 0, rs, rc, ro, lat, st);
    checks++;
    if (rs !== es || rc !== ec || ro !== eo) begin
      errors++;
      $display("FAIL %s: sum=%h c=%b o=%b, want %h %b %b",
               name, rs, rc, ro, es, ec, eo);
    end
    checks++;
    if (lat != 4 || !st) begin
      errors++;
      $display("FAIL %s_lat: lat=%0d hs=%b, want 4 1",
               name, lat, st);
    end
  endtask

  task automatic test_carry_chain();
    check_dir("carry_chain", 32'h00FF_FFFF, 32'h1,
              1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    check_dir("add_cin", 32'h0000_00FF, 32'h0,
              1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    check_dir("unsigned_ovf", 32'hFFFF_FFFF, 32'h1,
              1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_dir("signed_ovf", 32'h7FFF_FFFF, 32'h1,
              1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    check_dir("neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF,
              1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_subtract();
    check_dir("sub_borrow", 32'd5, 32'd7,
              1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    check_dir("sub_noborrow", 32'd7, 32'd5,
              1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    check_dir("sub_cin_ign", 32'd7, 32'd5,
              1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
    check_dir("sub_ovf", 32'h8000_0000, 32'd1,
              1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    a = 32'd100; b = 32'd200;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL bp_lat: lat=%0d, want 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sum !== 32'd7) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h, want 1 0 7",
                 i, out_valid, in_ready, sum);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b, want 0 1",
               out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: rdy=%b, want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || sum !== 32'd300) begin
      errors++;
      $display("FAIL bp_next: lat=%0d sum=%h, want 4 12c",
               lat, sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rs;
    logic        rc, ro, st;
    int          lat;
    a = 32'hAAAA_AAAA; b = 32'h5555_5555;
    cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b sum=%h c=%b o=%b, want 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    run_op4(32'd1, 32'd2, 1'b1, 1'b0, 0,
            rs, rc, ro, lat, st);
    checks++;
    if (rs !== 32'd4 || lat != 4) begin
      errors++;
      $display("FAIL after_reset: sum=%h lat=%0d, want 4 4",
               rs, lat);
    end
  endtask

  task automatic test_random4(input int n);
    logic [31:0] xa, xb, rs, es;
    logic        xc, xs, rc, ro, ec, eo, st;
    int          lat;
    for (int i = 0; i < n; i++) begin
      xa = $urandom;
      xb = $urandom;
      if (i % 4 == 0) xb = xa;
      xc = 1'($urandom_range(0, 1));
      xs = 1'($urandom_range(0, 1));
      run_op4(xa, xb, xc, xs, $urandom_range(0, 3),
              rs, rc, ro, lat, st);
      ref_model(32, xa, xb, xc, xs, es, ec, eo);
      checks++;
      if (rs !== es || rc !== ec || ro !== eo ||
          lat != 4 || !st) begin
        errors++;
        $display("FAIL rand4 %h %h c%b s%b: got %h %b %b lat=%0d hs=%b, want %h %b %b lat=4 hs=1",
                 xa, xb, xc, xs, rs, rc, ro, lat, st,
                 es, ec, eo);
      end
    end
  endtask

  task automatic test_random1(input int n);
    logic [31:0] es;
    logic [7:0]  xa, xb, rs;
    logic        xc, xs, rc, ro, ec, eo, st;
    int          lat;
    for (int i = 0; i < n; i++) begin
      xa = 8'($urandom);
      xb = 8'($urandom);
      xc = 1'($urandom_range(0, 1));
      xs = 1'($urandom_range(0, 1));
      run_op1(xa, xb, xc, xs, $urandom_range(0, 3),
              rs, rc, ro, lat, st);
      ref_model(8, {24'h0, xa}, {24'h0, xb},
                xc, xs, es, ec, eo);
      checks++;
      if (rs !== es[7:0] || rc !== ec || ro !== eo ||
          lat != 1 || !st) begin
        errors++;
        $display("FAIL rand1 %h %h c%b s%b: got %h %b %b lat=%0d hs=%b, want %h %b %b lat=1 hs=1",
                 xa, xb, xc, xs, rs, rc, ro, lat, st,
                 es[7:0], ec, eo);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0;
    cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_mid();
    test_random4(500);
    test_random1(500);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision adder/subtractor controller that time-multiplexes one 8-bit ripple-carry adder over NBYTES byte slices, least significant byte first.
- Carry is held in a register between slices.
- Sits between a valid/ready operand source and a valid/ready result sink, so wide additions reuse the 8-bit adder instead of a wide combinational adder.

Parameters:
- NBYTES, 4, number of byte slices; operand width W = 8*NBYTES; legal range 1..16.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  controller can accept an operation
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in for add; ignored for subtract
- sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1)
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts the result
- sum  output  W  result
- cout  output  1  final carry-out; for subtract, 1 means no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset state: IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; byte index=0; carry register=0.
- Reset is sampled only at the clock edge. If reset is asserted in any state, the controller returns to IDLE with the values above on the next edge, and any in-flight operation is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready (accept edge):
    - latch a into A_reg;
    - latch b into B_reg if sub=0, or ~b if sub=1;
    - latch sub into sub_reg;
    - carry_reg <= (sub ? 1 : cin);
    - idx <= 0;
    - go to BUSY.
  - in_valid without acceptance has no effect.
- BUSY
  - in_ready=0, out_valid=0.
  - Each cycle the adder is driven with A_reg[8*idx+:8], B_reg[8*idx+:8] and carry_reg.
  - At the edge:
    - sum[8*idx+:8] <= adder sum;
    - carry_reg <= adder carry-out;
    - idx <= idx+1.
  - When idx == NBYTES-1 at the edge:
    - cout <= adder carry-out;
    - ovf <= (A_reg[W-1] == B_reg[W-1]) && (adder sum bit7 != A_reg[W-1]);
    - go to DONE.
  - The adder is combinational; exactly one slice is processed per cycle.
- DONE
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_valid && out_ready: go to IDLE. out_valid deasserts on the next edge; sum, cout and ovf keep their values until the next operation writes them.
  - Backpressure: out_valid stays asserted indefinitely until out_ready is seen.
- Latency: out_valid rises exactly NBYTES cycles after the accept edge. Throughput: one operation per NBYTES+2 cycles, with out_ready tied high.
- Simultaneous events:
  - out_ready together with out_valid in DONE returns to IDLE. The next operation cannot be accepted in that same cycle because in_ready=0 in DONE.
  - in_valid is ignored in BUSY and DONE; the source must hold it until in_ready.
- Width rules:
  - sum wraps modulo 2^W.
  - No internal carry outside carry_reg. idx is ceil(log2(NBYTES)) bits, minimum 1 bit.
  - NBYTES=1: BUSY lasts one cycle.
- Outputs are registered; no combinational path from inputs to outputs except none (in_ready and out_valid decode state only).

Decomposition:
- Shared package:
  - state encoding enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - BYTE_W=8 constant.
- One sub-module: the team's existing 8-bit ripple-carry adder, instantiated once. The FSM, index counter, operand/carry registers and slice mux stay in mp_add_seq.

Test Plan:
- Add with carry chain: NBYTES=4, a=32'h00FF_FFFF, b=32'h0000_0001, cin=0, sub=0 -> sum=32'h0100_0000, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
- Unsigned and signed overflow: a=32'hFFFF_FFFF, b=1 -> sum=0, cout=1, ovf=0. Then a=32'h7FFF_FFFF, b=1 -> sum=32'h8000_0000, cout=0, ovf=1.
- Subtract, borrow and cin ignored:
  - a=5, b=7, sub=1, cin=0 -> sum=32'hFFFF_FFFE, cout=0 (borrow), ovf=0.
  - a=7, b=5, sub=1, cin=0 -> sum=2, cout=1.
- Backpressure and ignored requests: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands -> out_valid and sum stay stable, in_ready=0, no new operation starts. Release out_ready -> IDLE next cycle, then the new operation is accepted.
- Reset mid-operation: assert rst on the 2nd BUSY cycle -> next edge gives in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. The following op a=1, b=2, cin=1 yields sum=4.
- Random regression: 1000 random a/b/cin/sub with random out_ready stalls, for NBYTES=1 and 4 -> matches a W-bit reference model for sum, cout and ovf, with latency exactly NBYTES.
